lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu.sv | 148 ++++++++++++++
 tb/tb_lsu.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// the latched request payload and request classification.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] F3_B  = 3'b000;
    localparam logic [OP_W-1:0] F3_H  = 3'b001;
    localparam logic [OP_W-1:0] F3_W  = 3'b010;
    localparam logic [OP_W-1:0] F3_BU = 3'b100;
    localparam logic [OP_W-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              write;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // Illegal funct3, natural-alignment violation, or address beyond the memory.
    function automatic logic req_is_err(input logic write, input logic [OP_W-1:0] op,
                                        input logic [DATA_W-1:0] addr,
                                        input logic [DATA_W:0] limit);
        logic bad_op;
        logic misaligned;
        bad_op = write ? (op > F3_W) : ((op == 3'b011) || (op[2:1] == 2'b11));
        case (op[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = addr[1] | addr[0];
            default: misaligned = 1'b0;
        endcase
        return bad_op || misaligned || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend and store read-modify-write merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data_c,
    output logic [DATA_W-1:0] store_data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (lane)
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data_c = '0;
        case (op)
            F3_B:    load_data_c = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data_c = {{16{half_v[15]}}, half_v};
            F3_W:    load_data_c = word;
            F3_BU:   load_data_c = {24'd0, byte_v};
            F3_HU:   load_data_c = {16'd0, half_v};
            default: load_data_c = '0;
        endcase
    end

    // Untouched lanes keep the word read back from memory.
    always_comb begin
        store_data_c = word;
        case (op)
            F3_B: begin
                case (lane)
                    2'd0:    store_data_c[7:0]   = wdata[7:0];
                    2'd1:    store_data_c[15:8]  = wdata[7:0];
                    2'd2:    store_data_c[23:16] = wdata[7:0];
                    default: store_data_c[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (lane[1]) store_data_c[31:16] = wdata[15:0];
                else         store_data_c[15:0]  = wdata[15:0];
            end
            F3_W:    store_data_c = wdata;
            default: store_data_c = word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, sub-word stores done as
// read-modify-write against a word-wide memory.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_dat,
    output logic [OP_W-1:0]   mem_dat_op,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_r_dat
);

    localparam logic [DATA_W:0] ADDR_LIMIT = (DATA_W+1)'(MEM_WORDS) * (DATA_W+1)'(4);

    lsu_state_e        state;
    lsu_state_e        state_next;
    lsu_req_t          req_q;
    lsu_req_t          cur;
    logic              accept_c;
    logic              req_err_c;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] store_data_c;

    logic              ready_next;
    logic              resp_valid_next;
    logic              resp_err_next;
    logic [DATA_W-1:0] resp_rdata_next;
    logic              mem_read_next;
    logic              mem_write_next;
    logic [DATA_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_w_dat_next;
    logic [OP_W-1:0]   mem_dat_op_next;

    lsu_align u_align (
        .op           (cur.op),
        .lane         (cur.addr[1:0]),
        .word         (mem_r_dat),
        .wdata        (cur.wdata),
        .load_data_c  (load_data_c),
        .store_data_c (store_data_c)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_next      = state;
        cur             = req_q;
        accept_c        = 1'b0;
        ready_next      = 1'b0;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = '0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        mem_addr_next   = '0;
        mem_w_dat_next  = '0;
        mem_dat_op_next = '0;

        // In IDLE the request inputs stand in for the not-yet-latched fields.
        if (state == IDLE) begin
            cur = '{write: req_write, op: req_op, addr: req_addr, wdata: req_wdata};
        end
        req_err_c = req_is_err(cur.write, cur.op, cur.addr, ADDR_LIMIT);

        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    if (req_err_c) begin
                        state_next    = RESP;
                        resp_err_next = 1'b1;
                    end else if (cur.write && (cur.op == F3_W)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                if (cur.write) begin
                    state_next = WR;
                end else begin
                    state_next      = RESP;
                    resp_rdata_next = load_data_c;
                end
            end
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        ready_next      = (state_next == IDLE);
        resp_valid_next = (state_next == RESP);
        mem_read_next   = (state_next == RD);
        mem_write_next  = (state_next == WR);
        if (mem_read_next || mem_write_next) begin
            mem_addr_next   = {cur.addr[DATA_W-1:2], 2'b00};
            mem_dat_op_next = cur.op;
        end
        if (mem_write_next) begin
            mem_w_dat_next = store_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_w_dat  <= '0;
            mem_dat_op <= '0;
        end else begin
            state      <= state_next;
            if (accept_c) begin
                req_q <= cur;
            end
            req_ready  <= ready_next;
            resp_valid <= resp_valid_next;
            resp_err   <= resp_err_next;
            resp_rdata <= resp_rdata_next;
            mem_read   <= mem_read_next;
            mem_write  <= mem_write_next;
            mem_addr   <= mem_addr_next;
            mem_w_dat  <= mem_w_dat_next;
            mem_dat_op <= mem_dat_op_next;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a transaction-level model, plus directed
// cases with hand-computed results.
module tb_lsu;

    localparam int unsigned MW = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_dat;
    logic [2:0]  mem_dat_op;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_r_dat;

    always #5 clk = ~clk;

    lsu #(.MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_w_dat  (mem_w_dat),
        .mem_dat_op (mem_dat_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_r_dat  (mem_r_dat)
    );

    logic [31:0] mem     [MW];
    logic [31:0] ref_mem [MW];

    int checks = 0;
    int errors = 0;

    // Expected transaction currently in flight
    logic        active = 1'b0;
    int          cyc = 0;
    logic        e_err, e_rd, e_wr;
    logic [31:0] e_rdata, e_nword, e_addr;
    logic [2:0]  e_op;
    int          e_lat, e_idx;
    logic        done = 1'b0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    int          n_rd = 0, n_wr = 0;
    time         t_acc;

    logic        x_ready, x_rv, x_rs, x_ws;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: result, updated word, latency and strobes used.
    function automatic void model(input logic w, input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output logic err, output logic [31:0] rdata,
                                  output logic [31:0] nword, output int lat,
                                  output logic rd, output logic wr);
        int          sh;
        int          size;
        logic        legal;
        logic [31:0] t;
        logic [31:0] mask;
        sh    = 8 * int'(a[1:0]);
        size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        legal = w ? (op <= 3'd2) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || ((int'(a[1:0]) % size) != 0) || (a >= 32'(MW * 4));
        rdata = '0;
        nword = word;
        rd    = 1'b0;
        wr    = 1'b0;
        lat   = 1;
        t     = word >> sh;
        if (err) return;
        if (!w) begin
            lat = 2;
            rd  = 1'b1;
            case (op)
                3'd0:    rdata = 32'($signed(t[7:0]));
                3'd1:    rdata = 32'($signed(t[15:0]));
                3'd4:    rdata = {24'd0, t[7:0]};
                3'd5:    rdata = {16'd0, t[15:0]};
                default: rdata = word;
            endcase
        end else if (op == 3'd2) begin
            lat   = 2;
            wr    = 1'b1;
            nword = wd;
        end else begin
            lat   = 3;
            rd    = 1'b1;
            wr    = 1'b1;
            mask  = (op == 3'd0 ? 32'hFF : 32'hFFFF) << sh;
            nword = (word & ~mask) | ((wd << sh) & mask);
        end
    endfunction

    // Memory slave: read data appears on the falling edge, writes land on the rising edge.
    initial begin
        mem_r_dat = '0;
        forever begin
            @(negedge clk);
            if (mem_read && ((mem_addr >> 2) < 32'(MW))) mem_r_dat = mem[mem_addr[6:2]];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (mem_write && ((mem_addr >> 2) < 32'(MW))) mem[mem_addr[6:2]] = mem_w_dat;
        end
    end

    // Per-cycle compare against the in-flight expectation.
    initial begin
        forever begin
            @(negedge clk);
            n_rd += int'(mem_read);
            n_wr += int'(mem_write);
            if (!rst_n) begin
                chk("rst_req_ready", 32'(req_ready), 32'd1);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                chk("rst_resp_err", 32'(resp_err), 32'd0);
                chk("rst_resp_rdata", resp_rdata, 32'd0);
                chk("rst_mem_read", 32'(mem_read), 32'd0);
                chk("rst_mem_write", 32'(mem_write), 32'd0);
                chk("rst_mem_addr", mem_addr, 32'd0);
                chk("rst_mem_w_dat", mem_w_dat, 32'd0);
                chk("rst_mem_dat_op", 32'(mem_dat_op), 32'd0);
            end else begin
                if (active) cyc++;
                x_ready = !active || (cyc > e_lat);
                x_rv    = active && (cyc == e_lat);
                x_rs    = active && e_rd && (cyc == 1);
                x_ws    = active && e_wr && (cyc == (e_rd ? 2 : 1));
                chk("req_ready", 32'(req_ready), 32'(x_ready));
                chk("resp_valid", 32'(resp_valid), 32'(x_rv));
                chk("mem_read", 32'(mem_read), 32'(x_rs));
                chk("mem_write", 32'(mem_write), 32'(x_ws));
                chk("mem_addr", mem_addr, (x_rs || x_ws) ? {e_addr[31:2], 2'b00} : 32'd0);
                chk("mem_dat_op", 32'(mem_dat_op), (x_rs || x_ws) ? 32'(e_op) : 32'd0);
                if (x_ws) chk("mem_w_dat", mem_w_dat, e_nword);
                if (x_rv) begin
                    chk("resp_err", 32'(resp_err), 32'(e_err));
                    chk("resp_rdata", resp_rdata, e_rdata);
                    if (!e_err && e_wr) ref_mem[e_idx] = e_nword;
                end
                if (active && resp_valid) begin
                    last_rdata = resp_rdata;
                    last_err   = resp_err;
                    last_lat   = cyc;
                    done       = 1'b1;
                end
                if (active && cyc > e_lat) active = 1'b0;
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold);
        int          g;
        logic        err, r, wrs;
        logic [31:0] rdv, nw;
        int          lat;
        req_write = w;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model(w, op, a, wd, ref_mem[a[6:2]], err, rdv, nw, lat, r, wrs);
        e_err = err; e_rdata = rdv; e_nword = nw; e_lat = lat; e_rd = r; e_wr = wrs;
        e_addr = a; e_op = op; e_idx = int'(a[6:2]);
        cyc = 0; done = 1'b0; n_rd = 0; n_wr = 0; active = 1'b1; t_acc = $time;
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!done && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: resp_valid got 0 expected 1");
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [2:0]  op;
        logic [31:0] a;
        bit          hold;
        time         t1;
        int          k;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_op = '0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < int'(MW); i++) poke(i, $urandom);
        #22 rst_n = 1'b1;
        @(negedge clk);

        // Load word
        poke(3, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0); wait_done();
        chk("lw_rdata", last_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(last_err), 32'd0);
        chk("lw_latency", 32'(last_lat), 32'd2);

        // Sub-word loads with sign/zero extension
        poke(0, 32'h80FF7F01);
        issue(1'b0, 3'b000, 32'h03, 32'h0, 1'b0); wait_done();
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h03, 32'h0, 1'b0); wait_done();
        chk("lbu_rdata", last_rdata, 32'h00000080);
        issue(1'b0, 3'b001, 32'h02, 32'h0, 1'b0); wait_done();
        chk("lh_rdata", last_rdata, 32'hFFFF80FF);

        // Byte store read-modify-write
        poke(1, 32'h11223344);
        issue(1'b1, 3'b000, 32'h05, 32'hAA, 1'b0); wait_done();
        chk("sb_word", mem[1], 32'h1122AA44);
        chk("sb_latency", 32'(last_lat), 32'd3);
        chk("sb_rd_cycles", 32'(n_rd), 32'd1);
        chk("sb_wr_cycles", 32'(n_wr), 32'd1);

        // Rejected requests
        issue(1'b0, 3'b010, 32'h02, 32'h0, 1'b0); wait_done();
        chk("err_lw_mis", 32'(last_err), 32'd1);
        chk("err_lw_mis_lat", 32'(last_lat), 32'd1);
        chk("err_lw_mis_strobes", 32'(n_rd + n_wr), 32'd0);
        issue(1'b1, 3'b001, 32'h01, 32'h1234, 1'b0); wait_done();
        chk("err_sh_mis", 32'(last_err), 32'd1);
        chk("err_sh_mis_strobes", 32'(n_rd + n_wr), 32'd0);
        issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b0); wait_done();
        chk("err_op011", 32'(last_err), 32'd1);
        chk("err_op011_strobes", 32'(n_rd + n_wr), 32'd0);
        issue(1'b0, 3'b010, 32'h80, 32'h0, 1'b0); wait_done();
        chk("err_range", 32'(last_err), 32'd1);
        chk("err_range_lat", 32'(last_lat), 32'd1);
        chk("err_range_strobes", 32'(n_rd + n_wr), 32'd0);

        // Reset during the RD phase of a halfword store
        poke(4, 32'h55667788);
        issue(1'b1, 3'b001, 32'h12, 32'hBEEF, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        active = 1'b0;
        #1;
        chk("rmw_rst_mem_write", 32'(mem_write), 32'd0);
        chk("rmw_rst_mem_read", 32'(mem_read), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rmw_rst_no_write", 32'(n_wr), 32'd0);
        chk("rmw_rst_word", mem[4], 32'h55667788);

        // Back-to-back with req_valid held
        issue(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 1'b1);
        t1 = t_acc;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        chk("b2b_accept_gap", 32'((t_acc - t1) / 10), 32'd3);
        wait_done();
        chk("b2b_lw_rdata", last_rdata, 32'hCAFEF00D);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom % 2);
            if ($urandom % 4 != 0) begin
                k  = int'($urandom % 5);
                op = w ? 3'(k % 3) : ((k < 3) ? 3'(k) : 3'(k + 1));
            end else begin
                op = 3'($urandom_range(0, 7));
            end
            case ($urandom % 4)
                0:       a = 32'($urandom_range(0, MW - 1)) * 4;
                1:       a = 32'($urandom_range(0, MW - 1)) * 4 + {30'd0, 1'($urandom % 2), 1'b0};
                2:       a = 32'($urandom_range(0, MW - 1)) * 4 + 32'($urandom_range(0, 3));
                default: a = ($urandom % 8 == 0) ? 32'($urandom) : 32'(MW * 4) + 32'($urandom_range(0, 63));
            endcase
            hold = 1'($urandom % 2);
            issue(w, op, a, 32'($urandom), hold);
            if (!hold) begin
                wait_done();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        for (int i = 0; i < int'(MW); i++) chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
